// File: rtl/clock_rate_detector.sv
// rtl/clock_rate_detector.sv - recovers the 2-bit rate-select code from a slow square wave
//
// Purpose: measures the rising-to-rising period of sig_in in milliseconds of
// system clock and classifies it back into the rate code that produced it.
// Optional feature macro: RATE_DETECT_LOCK_EN (require two matching
// consecutive measurements before asserting valid).
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   sig_in     in   asynchronous slow square wave
//   code       out  recovered rate code (0=0.5s, 1=1s, 2=2s, 3=6s)
//   valid      out  code reflects a locked, in-window measurement
//   period_ms  out  last measured period in ms
//   meas_done  out  one-cycle pulse when period_ms updates
module clock_rate_detector #(
  parameter int TICKS_PER_MS = 50000,
  parameter int MS_MAX       = 8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_in,
  output logic [1:0]  code,
  output logic        valid,
  output logic [12:0] period_ms,
  output logic        meas_done
);

  localparam int MS_W = 13;
  localparam int PS_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_MS - 1);
  localparam logic [MS_W-1:0] MS_SAT  = MS_W'(MS_MAX);

  typedef enum logic {
    WAIT_EDGE,
    MEASURE
  } state_t;

  logic            sync1_q, sync2_q, sync3_q, rise_q;
  state_t          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [MS_W-1:0] period_q, period_d;
  logic [1:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
`ifdef RATE_DETECT_LOCK_EN
  logic [1:0]      lock_cnt_q, lock_cnt_d;
  logic [1:0]      lock_cls_q, lock_cls_d;
`endif

  logic            tick;
  logic            timeout;
  logic [MS_W-1:0] meas;
  logic [1:0]      cls;
  logic            in_win;

  // Two-flop synchronizer, one delay flop for edge detection, and a
  // registered rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= sync2_q & ~sync3_q;
    end
  end

  assign tick    = (ps_q == PS_LAST);
  assign timeout = (ms_cnt_q == MS_SAT);

  // A tick landing on the rise cycle completes the period being closed, so
  // it is folded into the latched value rather than carried into the next
  // count. This keeps k*TICKS_PER_MS + r cycles reading exactly k.
  assign meas = timeout ? MS_SAT : (ms_cnt_q + MS_W'(tick));

  always_comb begin
    cls    = 2'd0;
    in_win = 1'b1;
    if (meas >= 13'd250 && meas < 13'd750) begin
      cls = 2'd0;
    end else if (meas >= 13'd750 && meas < 13'd1500) begin
      cls = 2'd1;
    end else if (meas >= 13'd1500 && meas < 13'd4000) begin
      cls = 2'd2;
    end else if (meas >= 13'd4000 && meas < MS_SAT) begin
      cls = 2'd3;
    end else begin
      in_win = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    ps_d     = ps_q;
    ms_cnt_d = ms_cnt_q;
    period_d = period_q;
    code_d   = code_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
`ifdef RATE_DETECT_LOCK_EN
    lock_cnt_d = lock_cnt_q;
    lock_cls_d = lock_cls_q;
`endif
    case (state_q)
      WAIT_EDGE: begin
        ps_d     = '0;
        ms_cnt_d = '0;
        if (rise_q) begin
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise_q) begin
          ps_d     = '0;
          ms_cnt_d = '0;
          period_d = meas;
          done_d   = 1'b1;
          if (!in_win) begin
            valid_d = 1'b0;
`ifdef RATE_DETECT_LOCK_EN
            lock_cnt_d = 2'd0;
`endif
          end else begin
`ifdef RATE_DETECT_LOCK_EN
            if (lock_cnt_q != 2'd0 && cls == lock_cls_q) begin
              lock_cnt_d = 2'd2;
              code_d     = cls;
              valid_d    = 1'b1;
            end else begin
              // New class: restart the lock with this measurement as the first.
              lock_cnt_d = 2'd1;
              lock_cls_d = cls;
              valid_d    = 1'b0;
            end
`else
            code_d  = cls;
            valid_d = 1'b1;
`endif
          end
        end else if (timeout) begin
          state_d  = WAIT_EDGE;
          ps_d     = '0;
          ms_cnt_d = '0;
          code_d   = 2'd0;
          valid_d  = 1'b0;
`ifdef RATE_DETECT_LOCK_EN
          lock_cnt_d = 2'd0;
`endif
        end else begin
          ps_d = tick ? '0 : (ps_q + PS_W'(1));
          if (tick && ms_cnt_q != MS_SAT) begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_EDGE;
      ps_q     <= '0;
      ms_cnt_q <= '0;
      period_q <= '0;
      code_q   <= 2'd0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef RATE_DETECT_LOCK_EN
      lock_cnt_q <= 2'd0;
      lock_cls_q <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      ps_q     <= ps_d;
      ms_cnt_q <= ms_cnt_d;
      period_q <= period_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef RATE_DETECT_LOCK_EN
      lock_cnt_q <= lock_cnt_d;
      lock_cls_q <= lock_cls_d;
`endif
    end
  end

  assign code      = code_q;
  assign valid     = valid_q;
  assign period_ms = period_q;
  assign meas_done = done_q;

endmodule

// File: tb/tb_clock_rate_detector.sv
// tb/tb_clock_rate_detector.sv - scoreboard bench for clock_rate_detector
module tb_clock_rate_detector;

  localparam int T      = 2;
  localparam int MS_MAX = 8191;
  localparam int TO_CYC = 4 + T * MS_MAX + 1;

  logic        clk;
  logic        rst;
  logic        sig_in;
  logic [1:0]  code;
  logic        valid;
  logic [12:0] period_ms;
  logic        meas_done;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int per;
    int code;
    int vld;
  } exp_t;

  exp_t sb[$];

  clock_rate_detector #(
    .TICKS_PER_MS(T),
    .MS_MAX      (MS_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .code     (code),
    .valid    (valid),
    .period_ms(period_ms),
    .meas_done(meas_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every meas_done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && meas_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_meas_done: got period_ms=%0d code=%0d valid=%0d, expected no pulse",
                 period_ms, code, valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("period_ms", int'(period_ms), e.per);
        check("code", int'(code), e.code);
        check("valid", int'(valid), e.vld);
      end
    end
  end

  // One rise of sig_in, followed by ncyc cycles before the next rise.
  // The expectation describes the measurement this rise closes.
  task automatic pulse(input int ncyc, input bit exp_en, input int e_per,
                       input int code_nl, input int vld_nl,
                       input int code_lk, input int vld_lk);
    exp_t e;
    if (exp_en) begin
      e.per = e_per;
`ifdef RATE_DETECT_LOCK_EN
      e.code = code_lk;
      e.vld  = vld_lk;
`else
      e.code = code_nl;
      e.vld  = vld_nl;
`endif
      sb.push_back(e);
    end
    sig_in = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 3) check("meas_done_lat3", int'(meas_done), 0);
      if (k == 4) check("meas_done_lat4", int'(meas_done), exp_en ? 1 : 0);
      if (k == ncyc / 2) sig_in = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_period", int'(period_ms), 0);
    check("rst_done", int'(meas_done), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1000 ms wave, including a period with a 1-cycle remainder.
    pulse(2000, 0, 0,    0, 0, 0, 0);
    pulse(2000, 1, 1000, 1, 1, 0, 0);
    pulse(2001, 1, 1000, 1, 1, 1, 1);
    pulse(2000, 1, 1000, 1, 1, 1, 1);
    pulse(100,  1, 1000, 1, 1, 1, 1);
    // Out-of-window periods hold code; 249/250 boundary.
    pulse(499,  1, 50,   1, 0, 1, 0);
    pulse(500,  1, 249,  1, 0, 1, 0);
    pulse(500,  1, 250,  0, 1, 1, 0);
    pulse(4000, 1, 250,  0, 1, 0, 1);
    // Lock at 2 s.
    pulse(4000, 1, 2000, 2, 1, 0, 0);
    pulse(1000, 1, 2000, 2, 1, 2, 1);

    // Asynchronous reset mid-period while locked at code 2.
    #2;
    rst = 1'b1;
    #1;
    check("arst_code", int'(code), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_period", int'(period_ms), 0);
    check("arst_done", int'(meas_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Re-lock at 2 s, then switch to 6 s.
    pulse(4000,  0, 0,    0, 0, 0, 0);
    pulse(4000,  1, 2000, 2, 1, 0, 0);
    pulse(12000, 1, 2000, 2, 1, 2, 1);
    pulse(12000, 1, 6000, 3, 1, 2, 0);
    pulse(12000, 1, 6000, 3, 1, 3, 1);

    // sig_in held low: timeout one cycle after ms_cnt reaches MS_MAX.
    repeat (TO_CYC - 1 - 12000) @(negedge clk);
    check("pre_timeout_valid", int'(valid), 1);
    @(negedge clk);
    check("timeout_valid", int'(valid), 0);
    check("timeout_code", int'(code), 0);
    check("timeout_period", int'(period_ms), 6000);

    // After timeout the next rise only arms the measurement.
    pulse(2000, 0, 0,    0, 0, 0, 0);
    pulse(100,  1, 1000, 1, 1, 0, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
